// File: rtl/bit_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial operand serializer.
package bit_serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bsm_state_t;

    function automatic int unsigned frame_len(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/bit_serial_operand_serializer_shift_reg.sv
// One operand lane: loads an N-bit operand extended to a 2N-bit frame, shifts it out LSB-first.
// Extension mode selected by BSM_SIGN_EXTEND_EN (sign) or its absence (zero).
module bit_serial_shift_reg
    import bit_serial_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [N-1:0] i_data,
    output logic         o_bit
);

    localparam int unsigned F = frame_len(N);

    logic [F-1:0] r_sr;
    logic [F-1:0] w_ext;

`ifdef BSM_SIGN_EXTEND_EN
    assign w_ext = {{N{i_data[N-1]}}, i_data};
`else
    assign w_ext = {{N{1'b0}}, i_data};
`endif

    // Zeros shift in from the top, so a completed frame leaves the lane at 0 for IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= w_ext;
        end else if (i_shift) begin
            r_sr <= {1'b0, r_sr[F-1:1]};
        end
    end

    assign o_bit = r_sr[0];

endmodule

// File: rtl/bit_serial_operand_serializer.sv
// Streams N-bit operand pairs LSB-first as 2N-bit frames with first/last strobes.
// Extension mode controlled by BSM_SIGN_EXTEND_EN inside bit_serial_shift_reg.
module bit_serial_operand_serializer
    import bit_serial_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    input  logic [N-1:0] in_y,
    output logic         x,
    output logic         y,
    output logic         first_bit,
    output logic         last_bit,
    output logic         busy
);

    localparam int unsigned F  = frame_len(N);
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

    bsm_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_first, r_last, r_busy;
    logic          w_first_nxt, w_last_nxt, w_busy_nxt;
    logic          w_cnt_last;
    logic          w_xfer;
    logic          w_shift;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign in_ready   = !reset && ((r_state == IDLE) || ((r_state == SHIFT) && w_cnt_last));
    assign w_xfer     = in_valid && in_ready;
    assign w_shift    = (r_state == SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        if (w_xfer) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
            w_first_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
        end else if (r_state == SHIFT) begin
            if (w_cnt_last) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt  = r_cnt + 1'b1;
                w_last_nxt = ((r_cnt + 1'b1) == CNT_LAST);
                w_busy_nxt = 1'b1;
            end
        end
    end

    // Strobes are flopped from next-count decode so they align with the lane flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= w_first_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    bit_serial_shift_reg #(.N(N)) u_sr_x (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_xfer),
        .i_shift (w_shift),
        .i_data  (in_x),
        .o_bit   (x)
    );

    bit_serial_shift_reg #(.N(N)) u_sr_y (
        .i_clk   (clk),
        .i_reset (reset),
        .i_load  (w_xfer),
        .i_shift (w_shift),
        .i_data  (in_y),
        .o_bit   (y)
    );

    assign first_bit = r_first;
    assign last_bit  = r_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bit_serial_operand_serializer.sv
// Scoreboard bench for bit_serial_operand_serializer (N=8); honours BSM_SIGN_EXTEND_EN.
module tb_bit_serial_operand_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x, in_y;
    logic       x, y, first_bit, last_bit, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q[$];
    int         run_len  = 0;
    int         last_run = 0;
    int         cap_idx  = 16;
    logic [15:0] cap_x, cap_y;

    always #5 clk = ~clk;

    bit_serial_operand_serializer #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .x         (x),
        .y         (y),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ext(input logic [7:0] v);
`ifdef BSM_SIGN_EXTEND_EN
        return {{8{v[7]}}, v};
`else
        return {8'h00, v};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] ax, input logic [7:0] ay);
        logic [15:0] ex, ey;
        ex = ext(ax);
        ey = ext(ay);
        for (int i = 0; i < 16; i++)
            exp_q.push_back({ex[i], ey[i], (i == 0), (i == 15)});
    endtask

    // Waits (bounded) for in_ready, then transfers; returns cycles spent held off.
    task automatic send(input logic [7:0] ax, input logic [7:0] ay, input bit keep, output int waited);
        in_x     = ax;
        in_y     = ay;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never rose, got %b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        push_frame(ax, ay);
        tick();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            tick();
            g++;
        end
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic chk_idle(input string name);
        chk(name, {27'd0, x, y, first_bit, last_bit, busy}, 32'd0);
    endtask

    // Monitor: compares every busy cycle against the scoreboard; idle cycles must be all-zero.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (busy === 1'b1) begin
                run_len++;
                if (first_bit) cap_idx = 0;
                if (cap_idx < 16) begin
                    cap_x[cap_idx] = x;
                    cap_y[cap_idx] = y;
                    cap_idx++;
                end
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_bit: got x/y/first/last %b%b%b%b, expected no frame",
                             x, y, first_bit, last_bit);
                end else begin
                    chk("serial_bit", {28'd0, x, y, first_bit, last_bit}, {28'd0, exp_q.pop_front()});
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
                chk("idle_outputs", {28'd0, x, y, first_bit, last_bit}, 32'd0);
            end
        end
    end

    initial begin
        int w0, w1;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        repeat (3) tick();
        chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
        chk_idle("reset_outputs");
        reset = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Single frame 05 x 03: first at cycle 1, last at cycle 16, idle at cycle 17
        send(8'h05, 8'h03, 1'b0, w0);
        chk("single_first", {31'd0, first_bit}, 32'd1);
        repeat (15) tick();
        chk("single_last", {31'd0, last_bit}, 32'd1);
        tick();
        chk_idle("single_idle_c17");
        chk("single_ready_c17", {31'd0, in_ready}, 32'd1);
        chk("single_queue", exp_q.size(), 0);

        // Sign / zero extension of FF
        send(8'hFF, 8'h00, 1'b0, w0);
        drain();
        tick();
        chk_idle("ext_idle");

        // Back-to-back with in_valid held high
        send(8'hA5, 8'h3C, 1'b1, w0);
        chk("b2b_ready_c0", w0, 0);
        send(8'h81, 8'h7E, 1'b0, w1);
        chk("b2b_wait_to_cnt15", w1, 15);
        drain();
        tick();
        chk("b2b_busy_run", last_run, 32);

        // Backpressure: new pair offered at cnt=4
        send(8'h12, 8'h34, 1'b0, w0);
        repeat (4) tick();
        chk("bp_ready_low_cnt4", {31'd0, in_ready}, 32'd0);
        send(8'hC3, 8'h5A, 1'b0, w1);
        chk("bp_wait_to_cnt15", w1, 11);
        drain();
        tick();
        chk("bp_busy_run", last_run, 32);

        // Reset mid-frame at cnt=5
        send(8'h6B, 8'hD2, 1'b0, w0);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("rst_ready_gated", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk_idle("rst_outputs_cleared");
        chk("rst_ready_release", {31'd0, in_ready}, 32'd1);
        tick();
        chk_idle("rst_no_resume");
        send(8'h0F, 8'hF0, 1'b0, w0);
        chk("rst_clean_first", {31'd0, first_bit}, 32'd1);
        drain();
        tick();

        // End-to-end: -3 x 5 as serial frames, product truncated to 16 bits
        send(8'hFD, 8'h05, 1'b0, w0);
        drain();
        tick();
        chk("e2e_capture_len", cap_idx, 16);
`ifdef BSM_SIGN_EXTEND_EN
        chk("e2e_product", {16'd0, 16'(cap_x * cap_y)}, {16'd0, 16'hFFF1});
`else
        chk("e2e_product", {16'd0, 16'(cap_x * cap_y)}, {16'd0, 16'h04F1});
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_operand_serializer.md
# bit_serial_operand_serializer

Upstream feeder for `bit_serial_multiplier`. Accepts pairs of N-bit parallel operands over a valid/ready handshake and streams them LSB-first on the multiplier's `x` and `y` inputs. Each operand is extended to a 2N-bit frame so the full 2N-bit product emerges serially. The block generates the `first_bit`/`last_bit` framing strobes and supports back-to-back frames with no idle cycle.

## Interface
- `N`, default 8: operand width in bits. Must match the downstream multiplier's `N`. Legal range N ≥ 3.
- `clk` input, 1: single clock; all state is updated on its rising edge.
- `reset` input, 1: synchronous, active-high.
- `in_valid` input, 1: operand pair available.
- `in_ready` output, 1: block accepts a pair this cycle.
- `in_x` input, N: multiplicand, two's complement or unsigned (see Configuration).
- `in_y` input, N: multiplier operand.
- `x` output, 1: serial multiplicand bit to the multiplier.
- `y` output, 1: serial multiplier bit.
- `first_bit` output, 1: high on bit 0 of a frame.
- `last_bit` output, 1: high on bit 2N-1 of a frame.
- `busy` output, 1: a frame is on the outputs this cycle.

## Operation
- Frame length is F = 2N cycles. Each frame carries bits 0..N-1 of the operand, then N extension bits.
- **States:**
  - IDLE: no frame in flight.
  - SHIFT: frame in flight, with a bit counter `cnt` running 0..F-1.
- **Handshake:**
  - `in_ready` = (state == IDLE) or (state == SHIFT and cnt == F-1), gated low while `reset` is high.
  - A transfer occurs when `in_valid && in_ready` at a rising edge.
  - `in_x`/`in_y` are held stable by the source only until the transfer.
- **On transfer:**
  - Load both shift registers with the F-bit extended operand.
  - Set `cnt` to 0 and go to SHIFT.
- **In SHIFT:**
  - `x`/`y` carry bit `cnt` of their shift registers.
  - `first_bit` = (cnt == 0), `last_bit` = (cnt == F-1), `busy` = 1.
  - Each cycle, shift right by one and increment `cnt`.
- **At cnt == F-1:**
  - With a transfer: reload, set `cnt` to 0, stay in SHIFT. The next frame's `first_bit` immediately follows `last_bit`.
  - Without a transfer: go to IDLE.
- **In IDLE:** `x` = `y` = `first_bit` = `last_bit` = `busy` = 0. The multiplier sees zeros, so no spurious product is started.
- `in_valid` while in SHIFT with cnt < F-1 is held off by `in_ready` = 0. The operands are not sampled and nothing is lost.
- **Reset:**
  - Every registered output goes to 0 and the state goes to IDLE.
  - `in_ready` is 0 while `reset` is high and 1 in the first cycle after release.
- **Reset mid-frame:** the frame is aborted. Outputs are 0 from the cycle after the reset edge, and a partial frame is never resumed.
- The counter width is clog2(F). `cnt` never exceeds F-1.

## Timing
- All serial outputs are registered; there is no combinational path from `in_*` to `x`/`y`/strobes.
- `in_ready` is combinational from the state, `cnt` and `reset` only.
- **Latency:** a transfer at edge k produces `first_bit` = 1 with bit 0 in the cycle after edge k. `last_bit` appears F-1 cycles later.
- **Throughput:** one operand pair per F cycles when `in_valid` is held high, with 100% output occupancy.
- `first_bit` and `last_bit` are never high in the same cycle, because F ≥ 6.

## Configuration
- `BSM_SIGN_EXTEND_EN`:
  - **Defined:** upper N frame bits replicate operand bit N-1 (two's-complement sign extension). The serial product is a signed 2N-bit result.
  - **Undefined:** upper N frame bits are 0 (zero extension). The product is unsigned.
- No other behaviour changes between the two builds.

## Structure
- **Package `bit_serial_pkg`:**
  - function `frame_len(N)` returning 2N.
  - function `cnt_width(N)` returning clog2(2N).
  - enum `bsm_state_t` {IDLE, SHIFT}.
- **Sub-module `bit_serial_shift_reg`:**
  - Parameterised by N; instantiated twice, for x and y.
  - Ports: load, shift enable, N-bit parallel input, serial bit output.
  - Contains the extension logic under `BSM_SIGN_EXTEND_EN`.
- The FSM, counter and strobes live in the top block.

## Test plan
- **Single frame:** N=8, one transfer with `in_x`=8'h05, `in_y`=8'h03. Expect:
  - `x` = 1,0,1,0 then 12 zeros, and `y` = 1,1 then 14 zeros.
  - `first_bit` in cycle 1, `last_bit` in cycle 16.
  - IDLE with all outputs 0 in cycle 17.
- **Sign extension:** `in_x`=8'hFF.
  - With `BSM_SIGN_EXTEND_EN`: 16 ones on `x`.
  - Without it: 8 ones then 8 zeros.
- **Back-to-back:** `in_valid` held high for two pairs. Expect:
  - `in_ready` = 1 at cycle 0 and at cnt=15.
  - `last_bit` in cycle 16, `first_bit` in cycle 17.
  - `busy` continuously 1 for 32 cycles.
- **Backpressure:** assert `in_valid` with new operands at cnt=4.
  - `in_ready` stays 0 until cnt=15.
  - The new operands are taken at that edge, and the first frame completes unaltered.
- **Reset mid-frame:** assert `reset` at cnt=5 for one cycle. Expect:
  - All outputs 0 from the next cycle.
  - `in_ready` = 1 after release.
  - The next transfer starts a clean frame with `first_bit` = 1.
- **End-to-end:** feed the multiplier with N=8 signed operands (-3 × 5). Collect 16 product bits; the result must be 16'hFFF1.
